// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver: oversamples sclk/cs_n/mosi on clk, assembles a 1-8 byte
// frame per chip-select window and shifts a preloaded response word out on miso.
module spi_slave_rx #(
   parameter int MAX_BITS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   input  logic [63:0] tx_data,
   output logic [63:0] rx_data,
   output logic [3:0]  rx_bytes,
   output logic        rx_valid,
   output logic        rx_partial,
   output logic        rx_overflow,
   output logic        busy,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   // [0] and [1] form the synchroniser, [2] is the edge-detect history
   logic [2:0]  sclk_q;
   logic [2:0]  cs_q;
   logic [1:0]  mosi_q;
   logic        sync_live;
   logic        cs_armed;
   logic [6:0]  bit_cnt;
   logic [63:0] rx_shift;
   logic [63:0] tx_shift;
   logic        ovf_flag;

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q    <= 3'b000;
         cs_q      <= 3'b111;
         mosi_q    <= 2'b00;
         sync_live <= 1'b0;
         cs_armed  <= 1'b0;
      end else begin
         sclk_q    <= {sclk_q[1:0], spi_sclk};
         cs_q      <= {cs_q[1:0], spi_cs_n};
         mosi_q    <= {mosi_q[0], spi_mosi};
         sync_live <= 1'b1;
         // A frame may only start after cs_n has really been seen high since reset
         if (sync_live && cs_q[0])
            cs_armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = cs_armed & ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign mosi_bit  = mosi_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= 7'd0;
         rx_shift    <= 64'd0;
         tx_shift    <= 64'd0;
         ovf_flag    <= 1'b0;
         rx_data     <= 64'd0;
         rx_bytes    <= 4'd0;
         rx_valid    <= 1'b0;
         rx_partial  <= 1'b0;
         rx_overflow <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= ACTIVE;
                  bit_cnt  <= 7'd0;
                  rx_shift <= 64'd0;
                  tx_shift <= tx_data;
                  ovf_flag <= 1'b0;
               end
            end
            ACTIVE: begin
               if (sclk_rise) begin
                  if (bit_cnt < 7'(MAX_BITS)) begin
                     rx_shift <= {rx_shift[62:0], mosi_bit};
                     bit_cnt  <= bit_cnt + 7'd1;
                  end else begin
                     ovf_flag <= 1'b1;
                  end
               end
               if (sclk_fall)
                  tx_shift <= {tx_shift[62:0], 1'b0};
               if (cs_rise)
                  state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               if (bit_cnt != 7'd0) begin
                  rx_data     <= rx_shift >> bit_cnt[2:0];
                  rx_bytes    <= bit_cnt[6:3];
                  rx_partial  <= (bit_cnt[2:0] != 3'd0);
                  rx_overflow <= ovf_flag;
                  rx_valid    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == ACTIVE);
   assign spi_miso  = (state == ACTIVE) & tx_shift[63];
   assign fsm_state = state;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames from the test plan plus random frames,
// checked against a bit-list model of the frame and a scoreboard queue.
module tb_spi_slave_rx;

   localparam int MAXB = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_sclk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [63:0] tx_data = 64'd0;
   logic [63:0] rx_data;
   logic [3:0]  rx_bytes;
   logic        rx_valid;
   logic        rx_partial;
   logic        rx_overflow;
   logic        busy;
   logic [1:0]  fsm_state;

   int          n_checks = 0;
   int          n_errors = 0;
   int          busy_cnt = 0;
   logic [69:0] exp_q[$];
   logic [69:0] last_exp = 70'd0;
   logic [127:0] miso_got;

   spi_slave_rx #(.MAX_BITS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
      .rx_data(rx_data), .rx_bytes(rx_bytes), .rx_valid(rx_valid),
      .rx_partial(rx_partial), .rx_overflow(rx_overflow), .busy(busy),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [69:0] outs_now();
      return {rx_overflow, rx_partial, rx_bytes, rx_data};
   endfunction

   // Reference: keep the first MAXB bits in arrival order, drop trailing partial bits
   function automatic logic [69:0] model(input logic [127:0] vec, input int nbits);
      int          taken;
      logic [63:0] val;
      taken = (nbits > MAXB) ? MAXB : nbits;
      val = 64'd0;
      for (int i = 0; i < taken; i++)
         val = {val[62:0], vec[nbits-1-i]};
      val = val >> (taken % 8);
      return {nbits > MAXB, (taken % 8) != 0, 4'(taken / 8), val};
   endfunction

   function automatic logic [127:0] miso_model(input logic [63:0] tx, input int nbits);
      logic [127:0] m;
      m = 128'd0;
      for (int i = 0; i < nbits; i++)
         m = {m[126:0], (i < 64) ? tx[63-i] : 1'b0};
      return m;
   endfunction

   always @(negedge clk) begin
      if (rst_n && busy)
         busy_cnt++;
      if (rx_valid) begin
         if (exp_q.size() == 0)
            check("spurious_valid", 128'(outs_now()), 128'(last_exp));
         else
            check("rx_frame", 128'(outs_now()), 128'(exp_q.pop_front()));
      end
   end

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic clock_bits(input logic [127:0] vec, input int nbits, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         spi_mosi = vec[nbits-1-i];
         repeat (4) @(negedge clk);
         miso_got = {miso_got[126:0], spi_miso};
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [127:0] vec, input int nbits, input logic [63:0] tx);
      logic [69:0] e;
      tx_data = tx;
      e = model(vec, nbits);
      exp_q.push_back(e);
      last_exp = e;
      miso_got = 128'd0;
      cs_low();
      clock_bits(vec, nbits, 0, nbits);
      cs_high();
      check("miso", miso_got, miso_model(tx, nbits));
      check("valid_seen", 128'(exp_q.size()), 128'd0);
      check("held", 128'(outs_now()), 128'(last_exp));
      check("busy_idle", 128'(busy), 128'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] v;
      int           n;
      repeat (3) @(negedge clk);
      check("reset_outs", 128'({outs_now(), rx_valid, busy, spi_miso}), 128'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      send_frame(128'h00f0, 16, $urandom());
      check("two_byte", 128'(outs_now()), 128'({1'b0, 1'b0, 4'd2, 64'h00f0}));

      send_frame(128'h04_00ff_ffff, 40, 64'hA5C3_0000_0000_0000);
      check("five_byte", 128'(outs_now()), 128'({1'b0, 1'b0, 4'd5, 64'h04_00ff_ffff}));
      check("five_miso", 128'(miso_got[39:0]), 128'(40'hA5C3_0000_00));

      send_frame(128'h01_0203_0405_0607_0809, 72, {$urandom(), $urandom()});
      check("overflow", 128'(outs_now()), 128'({1'b1, 1'b0, 4'd8, 64'h0102_0304_0506_0708}));

      send_frame(128'b101_1010_1011, 11, {$urandom(), $urandom()});
      check("partial", 128'(outs_now()), 128'({1'b0, 1'b1, 4'd1, 64'hB5}));

      busy_cnt = 0;
      cs_low();
      repeat (6) @(negedge clk);
      cs_high();
      check("empty_busy", 128'(busy_cnt != 0), 128'd1);
      check("empty_held", 128'(outs_now()), 128'(last_exp));

      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      miso_got = 128'd0;
      tx_data = {$urandom(), $urandom()};
      cs_low();
      clock_bits(v, 32, 0, 20);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_reset_outs", 128'({outs_now(), rx_valid, busy, spi_miso}), 128'd0);
      rst_n = 1'b1;
      last_exp = 70'd0;
      clock_bits(v, 32, 20, 12);
      cs_high();
      check("after_reset_outs", 128'({outs_now(), busy, spi_miso}), 128'd0);

      send_frame(128'h00f0, 16, $urandom());
      check("post_reset_frame", 128'(outs_now()), 128'({1'b0, 1'b0, 4'd2, 64'h00f0}));

      for (int k = 0; k < 16; k++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         n = $urandom_range(1, 80);
         send_frame(v, n, {$urandom(), $urandom()});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
